fp_norm_round_seq: RTL and testbench

Parametrised, multi-cycle normalise-and-round stage for the floating-point adder datapath. It takes the raw sum from the significand adder (carry, hidden bit, fraction, G/R/S) and the larger-operand exponent, then normalises it right or left and rounds it under a selectable IEEE-754 mode. It produces the packed exponent/fraction plus status flags. It sits between the significand adder and the result packer, with a valid/ready handshake on both sides.

---
 rtl/fp_norm_pkg.sv | 28 ++
 rtl/fp_lzc.sv | 18 +
 rtl/fp_norm_round_seq.sv | 270 +++++++++++++++++++++++++++
 tb/tb_fp_norm_round_seq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fp_norm_pkg.sv
// Shared rounding-mode codes, FSM states and exponent helpers for the
// floating-point normalise-and-round stage.
package fp_norm_pkg;

    localparam logic [1:0] RND_RNE = 2'b00;
    localparam logic [1:0] RND_RTZ = 2'b01;
    localparam logic [1:0] RND_RUP = 2'b10;
    localparam logic [1:0] RND_RDN = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RSHIFT,
        ST_LSHIFT,
        ST_ROUND,
        ST_POSTNORM,
        ST_DONE
    } state_t;

    function automatic logic [31:0] exp_all_ones(input int exp_w);
        return (32'd1 << exp_w) - 32'd1;
    endfunction

    // Largest biased exponent of a finite number.
    function automatic logic [31:0] max_finite(input int exp_w);
        return exp_all_ones(exp_w) - 32'd1;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter; returns W when the input is all zeros.
module fp_lzc #(
    parameter int W  = 24,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  din,
    output logic [CW-1:0] cnt
);

    // Scan upward so the most significant set bit gives the final answer.
    always_comb begin
        cnt = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (din[i]) cnt = CW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/fp_norm_round_seq.sv
// Multi-cycle normalise-and-round stage between the significand adder and
// the result packer, with valid/ready handshakes on both sides.
module fp_norm_round_seq
    import fp_norm_pkg::*;
#(
    parameter int EXP_W      = 8,
    parameter int MAN_W      = 23,
    parameter int SHIFT_STEP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [MAN_W+1:0] in_frac,
    input  logic [2:0]       in_grs,
    input  logic [1:0]       in_rnd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [EXP_W-1:0] out_exp,
    output logic [MAN_W-1:0] out_frac,
    output logic             out_zero,
    output logic             out_ovf,
    output logic             out_unf,
    output logic             out_inexact
);

    localparam int FW = MAN_W + 2;
    localparam int XW = EXP_W + 1;
    localparam int LW = $clog2(MAN_W + 2);
    localparam logic [EXP_W-1:0] EXP_ONES_E = EXP_W'(exp_all_ones(EXP_W));
    localparam logic [EXP_W-1:0] EXP_MAXF_E = EXP_W'(max_finite(EXP_W));
    localparam logic [XW-1:0]    EXP_ONES_X = {1'b0, EXP_ONES_E};

    function automatic logic round_inc(input logic [1:0] rnd, input logic sign,
                                       input logic lsb, input logic g,
                                       input logic r, input logic s);
        case (rnd)
            RND_RNE: return g & (r | s | lsb);
            RND_RUP: return (g | r | s) & ~sign;
            RND_RDN: return (g | r | s) & sign;
            default: return 1'b0;
        endcase
    endfunction

    // Overflow saturates to infinity only when the mode rounds away from zero.
    function automatic logic [EXP_W+MAN_W-1:0] ovf_result(input logic [1:0] rnd,
                                                          input logic sign);
        if ((rnd == RND_RNE) || (rnd == RND_RUP && !sign) || (rnd == RND_RDN && sign))
            return {EXP_ONES_E, {MAN_W{1'b0}}};
        return {EXP_MAXF_E, {MAN_W{1'b1}}};
    endfunction

    state_t           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             out_sign_q, out_sign_d;
    logic [EXP_W-1:0] out_exp_q, out_exp_d;
    logic [MAN_W-1:0] out_frac_q, out_frac_d;
    logic             out_zero_q, out_zero_d;
    logic             out_ovf_q, out_ovf_d;
    logic             out_unf_q, out_unf_d;
    logic             out_inexact_q, out_inexact_d;

    logic             sign_q, sign_d;
    logic [1:0]       rnd_q, rnd_d;
    logic [XW-1:0]    exp_q, exp_d;
    logic [FW-1:0]    frac_q, frac_d;
    logic             g_q, g_d, r_q, r_d, s_q, s_d;
    logic             inexact_q, inexact_d;

    logic             done_en, done_sign, done_zero, done_ovf, done_unf, done_inexact;
    logic [EXP_W-1:0] done_exp;
    logic [MAN_W-1:0] done_frac;
    logic [LW-1:0]    lz;
    logic [31:0]      k_amt;
    logic [MAN_W+2:0] lsh_out;
    logic [XW-1:0]    lsh_exp, exp_inc;
    logic             rnd_up, rnd_inexact;
    logic [FW-1:0]    rnd_sum;

    fp_lzc #(.W(MAN_W + 1), .CW(LW)) u_lzc (
        .din (frac_q[MAN_W:0]),
        .cnt (lz)
    );

    always_comb begin
        state_d       = state_q;
        in_ready_d    = in_ready_q;
        out_valid_d   = out_valid_q;
        out_sign_d    = out_sign_q;
        out_exp_d     = out_exp_q;
        out_frac_d    = out_frac_q;
        out_zero_d    = out_zero_q;
        out_ovf_d     = out_ovf_q;
        out_unf_d     = out_unf_q;
        out_inexact_d = out_inexact_q;
        sign_d        = sign_q;
        rnd_d         = rnd_q;
        exp_d         = exp_q;
        frac_d        = frac_q;
        g_d           = g_q;
        r_d           = r_q;
        s_d           = s_q;
        inexact_d     = inexact_q;
        done_en       = 1'b0;
        done_sign     = sign_q;
        done_exp      = '0;
        done_frac     = '0;
        done_zero     = 1'b0;
        done_ovf      = 1'b0;
        done_unf      = 1'b0;
        done_inexact  = 1'b0;

        // Left-shift distance is capped so the exponent never drops below 1.
        k_amt = 32'(lz);
        if (k_amt > 32'(SHIFT_STEP)) k_amt = 32'(SHIFT_STEP);
        if (k_amt > 32'(exp_q) - 32'd1) k_amt = 32'(exp_q) - 32'd1;
        lsh_out     = {frac_q[MAN_W:0], g_q, r_q} << k_amt;
        lsh_exp     = exp_q - XW'(k_amt);
        exp_inc     = exp_q + XW'(1);
        rnd_up      = round_inc(rnd_q, sign_q, frac_q[0], g_q, r_q, s_q);
        rnd_inexact = g_q | r_q | s_q;
        rnd_sum     = frac_q + FW'(rnd_up);

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    in_ready_d = 1'b0;
                    sign_d     = in_sign;
                    rnd_d      = in_rnd;
                    exp_d      = (in_exp == '0) ? XW'(1) : {1'b0, in_exp};
                    frac_d     = in_frac;
                    {g_d, r_d, s_d} = in_grs;
                    if (in_frac == '0 && in_grs == 3'b000) begin
                        done_en   = 1'b1;
                        done_sign = in_sign;
                        done_zero = 1'b1;
                    end else if (in_frac[MAN_W+1]) begin
                        state_d = ST_RSHIFT;
                    end else if (in_frac[MAN_W]) begin
                        state_d = ST_ROUND;
                    end else begin
                        state_d = ST_LSHIFT;
                    end
                end
            end
            ST_RSHIFT: begin
                frac_d = frac_q >> 1;
                g_d    = frac_q[0];
                r_d    = g_q;
                s_d    = s_q | r_q;
                exp_d  = exp_inc;
                if (exp_inc >= EXP_ONES_X) begin
                    done_en      = 1'b1;
                    {done_exp, done_frac} = ovf_result(rnd_q, sign_q);
                    done_ovf     = 1'b1;
                    done_inexact = 1'b1;
                end else begin
                    state_d = ST_ROUND;
                end
            end
            ST_LSHIFT: begin
                frac_d = {1'b0, lsh_out[MAN_W+2:2]};
                g_d    = lsh_out[1];
                r_d    = lsh_out[0];
                exp_d  = lsh_exp;
                if (lsh_out[MAN_W+2] || lsh_exp == XW'(1)) state_d = ST_ROUND;
            end
            ST_ROUND: begin
                if (rnd_sum[MAN_W+1]) begin
                    frac_d    = rnd_sum;
                    inexact_d = rnd_inexact;
                    state_d   = ST_POSTNORM;
                end else begin
                    // A subnormal that rounds into the hidden bit becomes normal with exp 1.
                    done_en      = 1'b1;
                    done_exp     = rnd_sum[MAN_W] ? exp_q[EXP_W-1:0] : '0;
                    done_frac    = rnd_sum[MAN_W-1:0];
                    done_zero    = ~rnd_sum[MAN_W] && (rnd_sum[MAN_W-1:0] == '0);
                    done_unf     = ~rnd_sum[MAN_W] & rnd_inexact;
                    done_inexact = rnd_inexact;
                end
            end
            ST_POSTNORM: begin
                done_en      = 1'b1;
                done_inexact = inexact_q;
                if (exp_inc >= EXP_ONES_X) begin
                    {done_exp, done_frac} = ovf_result(rnd_q, sign_q);
                    done_ovf     = 1'b1;
                    done_inexact = 1'b1;
                end else begin
                    done_exp  = exp_inc[EXP_W-1:0];
                    done_frac = frac_q[MAN_W:1];
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (done_en) begin
            state_d       = ST_DONE;
            out_valid_d   = 1'b1;
            out_sign_d    = done_sign;
            out_exp_d     = done_exp;
            out_frac_d    = done_frac;
            out_zero_d    = done_zero;
            out_ovf_d     = done_ovf;
            out_unf_d     = done_unf;
            out_inexact_d = done_inexact;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            out_sign_q    <= 1'b0;
            out_exp_q     <= '0;
            out_frac_q    <= '0;
            out_zero_q    <= 1'b0;
            out_ovf_q     <= 1'b0;
            out_unf_q     <= 1'b0;
            out_inexact_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            out_sign_q    <= out_sign_d;
            out_exp_q     <= out_exp_d;
            out_frac_q    <= out_frac_d;
            out_zero_q    <= out_zero_d;
            out_ovf_q     <= out_ovf_d;
            out_unf_q     <= out_unf_d;
            out_inexact_q <= out_inexact_d;
        end
    end

    // Working operand registers are only meaningful after an accept.
    always_ff @(posedge clk) begin
        sign_q    <= sign_d;
        rnd_q     <= rnd_d;
        exp_q     <= exp_d;
        frac_q    <= frac_d;
        g_q       <= g_d;
        r_q       <= r_d;
        s_q       <= s_d;
        inexact_q <= inexact_d;
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_sign    = out_sign_q;
    assign out_exp     = out_exp_q;
    assign out_frac    = out_frac_q;
    assign out_zero    = out_zero_q;
    assign out_ovf     = out_ovf_q;
    assign out_unf     = out_unf_q;
    assign out_inexact = out_inexact_q;

endmodule

// File: tb/tb_fp_norm_round_seq.sv
// Directed bench for fp_norm_round_seq (single-precision configuration).
module tb_fp_norm_round_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_sign;
    logic [7:0]  in_exp;
    logic [24:0] in_frac;
    logic [2:0]  in_grs;
    logic [1:0]  in_rnd;
    logic        out_valid, out_ready, out_sign;
    logic [7:0]  out_exp;
    logic [22:0] out_frac;
    logic        out_zero, out_ovf, out_unf, out_inexact;

    int total = 0;
    int bad   = 0;
    int lat;

    fp_norm_round_seq #(.EXP_W(8), .MAN_W(23), .SHIFT_STEP(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
        .in_exp(in_exp), .in_frac(in_frac), .in_grs(in_grs), .in_rnd(in_rnd),
        .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
        .out_exp(out_exp), .out_frac(out_frac), .out_zero(out_zero),
        .out_ovf(out_ovf), .out_unf(out_unf), .out_inexact(out_inexact)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept one operand and count clock edges until out_valid rises.
    task automatic run_op(input string tag, input logic s, input logic [7:0] e,
                          input logic [24:0] f, input logic [2:0] grs,
                          input logic [1:0] rnd, output int n);
        @(negedge clk);
        chk({tag, ".in_ready"}, in_ready, 1);
        in_sign = s; in_exp = e; in_frac = f; in_grs = grs; in_rnd = rnd;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ".valid"}, out_valid, 1);
    endtask

    task automatic check_res(input string tag, input int n, input int n_exp,
                             input logic [7:0] e, input logic [22:0] f, input logic z,
                             input logic o, input logic u, input logic ix);
        chk({tag, ".lat"}, 64'(n), 64'(n_exp));
        chk({tag, ".exp"}, out_exp, e);
        chk({tag, ".frac"}, out_frac, f);
        chk({tag, ".zero"}, out_zero, z);
        chk({tag, ".ovf"}, out_ovf, o);
        chk({tag, ".unf"}, out_unf, u);
        chk({tag, ".inexact"}, out_inexact, ix);
    endtask

    task automatic pop(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ".rel_valid"}, out_valid, 0);
        chk({tag, ".rel_ready"}, in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_sign = 1'b0;
        in_exp = '0; in_frac = '0; in_grs = '0; in_rnd = 2'b00;
        #1;
        chk("reset.in_ready", in_ready, 1);
        chk("reset.out_valid", out_valid, 0);
        chk("reset.out_exp", out_exp, 0);
        chk("reset.out_frac", out_frac, 0);
        chk("reset.flags", {out_sign, out_zero, out_ovf, out_unf, out_inexact}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Carry out of the adder: one right shift, exact
        run_op("carry", 0, 8'd25, 25'b1110111110010110111110010, 3'b000, 2'b00, lat);
        check_res("carry", lat, 2, 8'd26, 23'h6F96F9, 0, 0, 0, 0);
        pop("carry");

        run_op("lshift", 0, 8'd125, 25'b0000111110010110111110010, 3'b000, 2'b00, lat);
        check_res("lshift", lat, 2, 8'd122, 23'h796F90, 0, 0, 0, 0);
        pop("lshift");

        // Rounding carries out of the significand
        run_op("rc_rne", 0, 8'd100, 25'h0FFFFFF, 3'b100, 2'b00, lat);
        check_res("rc_rne", lat, 2, 8'd101, 23'h000000, 0, 0, 0, 1);
        pop("rc_rne");

        run_op("rc_rtz", 0, 8'd100, 25'h0FFFFFF, 3'b100, 2'b01, lat);
        check_res("rc_rtz", lat, 1, 8'd100, 23'h7FFFFF, 0, 0, 0, 1);
        pop("rc_rtz");

        // Ties-to-even and directed rounding on a normal result
        run_op("tie_even", 0, 8'd50, 25'h0800000, 3'b100, 2'b00, lat);
        check_res("tie_even", lat, 1, 8'd50, 23'h000000, 0, 0, 0, 1);
        pop("tie_even");

        run_op("tie_odd", 0, 8'd50, 25'h0800001, 3'b100, 2'b00, lat);
        check_res("tie_odd", lat, 1, 8'd50, 23'h000002, 0, 0, 0, 1);
        pop("tie_odd");

        run_op("rup_pos", 0, 8'd50, 25'h0800000, 3'b001, 2'b10, lat);
        check_res("rup_pos", lat, 1, 8'd50, 23'h000001, 0, 0, 0, 1);
        pop("rup_pos");

        // Overflow from the right shift
        run_op("ovf_rne", 0, 8'd254, 25'h1000000, 3'b000, 2'b00, lat);
        check_res("ovf_rne", lat, 1, 8'd255, 23'h000000, 0, 1, 0, 1);
        pop("ovf_rne");

        run_op("ovf_rtz", 0, 8'd254, 25'h1000000, 3'b000, 2'b01, lat);
        check_res("ovf_rtz", lat, 1, 8'd254, 23'h7FFFFF, 0, 1, 0, 1);
        pop("ovf_rtz");

        run_op("ovf_rdn_pos", 0, 8'd254, 25'h1000000, 3'b000, 2'b11, lat);
        check_res("ovf_rdn_pos", lat, 1, 8'd254, 23'h7FFFFF, 0, 1, 0, 1);
        pop("ovf_rdn_pos");

        run_op("ovf_rdn_neg", 1, 8'd254, 25'h1000000, 3'b000, 2'b11, lat);
        check_res("ovf_rdn_neg", lat, 1, 8'd255, 23'h000000, 0, 1, 0, 1);
        chk("ovf_rdn_neg.sign", out_sign, 1);
        pop("ovf_rdn_neg");

        // Subnormal results
        run_op("subn", 0, 8'd3, 25'h0000010, 3'b000, 2'b00, lat);
        check_res("subn", lat, 2, 8'd0, 23'h000040, 0, 0, 0, 0);
        pop("subn");

        run_op("subn_inx", 0, 8'd1, 25'h0000010, 3'b100, 2'b01, lat);
        check_res("subn_inx", lat, 2, 8'd0, 23'h000010, 0, 0, 1, 1);
        pop("subn_inx");

        run_op("zero", 0, 8'd77, 25'h0000000, 3'b000, 2'b00, lat);
        check_res("zero", lat, 0, 8'd0, 23'h000000, 1, 0, 0, 0);
        pop("zero");

        // Backpressure: result must hold while out_ready is low
        run_op("bp", 0, 8'd125, 25'b0000111110010110111110010, 3'b000, 2'b00, lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp.valid", out_valid, 1);
            chk("bp.exp", out_exp, 8'd122);
            chk("bp.frac", out_frac, 23'h796F90);
            chk("bp.in_ready", in_ready, 0);
        end
        pop("bp");

        // Asynchronous reset while shifting left
        @(negedge clk);
        in_sign = 0; in_exp = 8'd125; in_frac = 25'h0000001; in_grs = 3'b000; in_rnd = 2'b00;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rst_ls.busy", in_ready, 0);
        #2 rst = 1'b1;
        #1;
        chk("rst_ls.in_ready", in_ready, 1);
        chk("rst_ls.out_valid", out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        in_exp = 8'd9; in_frac = '0; in_grs = 3'b000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rst_ls.accept_ready", in_ready, 0);
        chk("rst_ls.accept_valid", out_valid, 1);
        chk("rst_ls.accept_zero", out_zero, 1);

        // Asynchronous reset while a result is waiting
        #2 rst = 1'b1;
        #1;
        chk("rst_done.out_valid", out_valid, 0);
        chk("rst_done.out_zero", out_zero, 0);
        chk("rst_done.in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        run_op("post_rst", 0, 8'd25, 25'b1110111110010110111110010, 3'b000, 2'b00, lat);
        check_res("post_rst", lat, 2, 8'd26, 23'h6F96F9, 0, 0, 0, 0);
        pop("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
